// File: rtl/io_stim_pkg.sv
// Shared constants and types for the io_stim_gen stimulus generator:
// Wishbone register map, FSM state encoding and field widths.
package io_stim_pkg;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_CFG_BASE = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_START    = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_STOP     = 4'hA;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } stim_state_t;

    function automatic logic [ADDR_W-1:0] cfg_addr(input int idx);
        return ADDR_CFG_BASE + ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/io_stim_gen_if.sv
// Wishbone-style slave bus used by io_stim_gen: single-word accesses,
// acked one cycle after wb_cyc.
interface io_stim_gen_if;
    import io_stim_pkg::*;

    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_rdata;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_we;
    logic              wb_cyc;
    logic              wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );

endinterface

// File: rtl/io_stim_line.sv
// One driven IO line: alternates HI/LO phases of programmable tick lengths
// while running, otherwise holds the idle level. Output is registered.
module io_stim_line
    import io_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] hi_ticks,
    input  logic [CNT_W-1:0] lo_ticks,
    input  logic             idle_level,
    input  logic             run,
    output logic             level
);

    logic             r_phase_hi;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             w_active;

    assign w_active = run && (hi_ticks != '0 || lo_ticks != '0);
    assign level    = r_level;

    // Phase lengths are sampled only at a reload, so a CFG write mid-phase
    // never truncates the phase already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_hi <= 1'b0;
            r_count    <= '0;
            r_level    <= 1'b0;
        end else begin
            r_level <= w_active ? r_phase_hi : idle_level;
            if (load) begin
                r_phase_hi <= (hi_ticks != '0);
                r_count    <= (hi_ticks != '0) ? hi_ticks : lo_ticks;
            end else if (run && tick) begin
                if (r_count <= CNT_W'(1)) begin
                    if (r_phase_hi) begin
                        if (lo_ticks != '0) begin
                            r_phase_hi <= 1'b0;
                            r_count    <= lo_ticks;
                        end else begin
                            r_count    <= hi_ticks;
                        end
                    end else begin
                        if (hi_ticks != '0) begin
                            r_phase_hi <= 1'b1;
                            r_count    <= hi_ticks;
                        end else begin
                            r_count    <= lo_ticks;
                        end
                    end
                end else begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/io_stim_gen.sv
// Wishbone-controlled stimulus generator: bus registers, tick prescaler,
// burst counter and run FSM driving N_LINES io_stim_line instances.
module io_stim_gen #(
    parameter int TICK_DIV = 9,
    parameter int N_LINES  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    io_stim_gen_if.slave       bus,
    output logic [N_LINES-1:0] io_out,
    output logic [N_LINES-1:0] io_oe
);
    import io_stim_pkg::*;

    localparam int               PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic               r_ack;
    logic [DATA_W-1:0]  r_cfg [N_LINES];
    logic [N_LINES-1:0] r_oe_mask;
    logic [N_LINES-1:0] r_idle_level;
    stim_state_t        r_state;
    logic [PS_W-1:0]    r_presc;
    logic [CNT_W-1:0]   r_remaining;

    logic               w_wr;
    logic               w_start;
    logic               w_stop;
    logic               w_load;
    logic               w_run;
    logic               w_tick;
    logic [DATA_W-1:0]  w_ctrl;
    logic [DATA_W-1:0]  w_rdata;
    logic [N_LINES-1:0] w_level;

    assign w_wr    = r_ack && bus.wb_cyc && bus.wb_we;
    assign w_start = w_wr && (bus.wb_addr == ADDR_START);
    assign w_stop  = w_wr && (bus.wb_addr == ADDR_STOP);
    assign w_load  = w_start && (bus.wb_wdata[CNT_W-1:0] != '0);
    assign w_run   = (r_state == ST_RUN);
    assign w_tick  = w_run && (r_presc == PS_LAST);

    assign bus.wb_ack   = r_ack;
    assign bus.wb_rdata = w_rdata;
    assign io_oe        = r_oe_mask;
    assign io_out       = w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= bus.wb_cyc && !r_ack;
        end
    end

    // Writes take effect on the edge that closes the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LINES; i++) begin
                r_cfg[i] <= '0;
            end
            r_oe_mask    <= '0;
            r_idle_level <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < N_LINES; i++) begin
                if (bus.wb_addr == cfg_addr(i)) begin
                    r_cfg[i] <= bus.wb_wdata;
                end
            end
            if (bus.wb_addr == ADDR_CTRL) begin
                r_oe_mask    <= bus.wb_wdata[N_LINES-1:0];
                r_idle_level <= bus.wb_wdata[8 +: N_LINES];
            end
        end
    end

    // A START with a nonzero length always restarts from scratch, even mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_presc     <= '0;
            r_remaining <= bus.wb_wdata[CNT_W-1:0];
            r_state     <= w_load ? ST_RUN : ST_IDLE;
        end else if (w_stop) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
        end else if (w_run) begin
            if (w_tick) begin
                r_presc <= '0;
                if (r_remaining == CNT_W'(1)) begin
                    r_state     <= ST_IDLE;
                    r_remaining <= '0;
                end else begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
            end else begin
                r_presc <= r_presc + PS_W'(1);
            end
        end
    end

    always_comb begin
        w_ctrl                   = '0;
        w_ctrl[N_LINES-1:0]      = r_oe_mask;
        w_ctrl[8 +: N_LINES]     = r_idle_level;
    end

    always_comb begin
        w_rdata = '0;
        if (r_ack && bus.wb_cyc) begin
            for (int i = 0; i < N_LINES; i++) begin
                if (bus.wb_addr == cfg_addr(i)) begin
                    w_rdata = r_cfg[i];
                end
            end
            if (bus.wb_addr == ADDR_CTRL) begin
                w_rdata = w_ctrl;
            end else if (bus.wb_addr == ADDR_START) begin
                w_rdata = {w_run, 15'b0, r_remaining};
            end
        end
    end

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        io_stim_line u_line (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (w_load),
            .tick       (w_tick),
            .hi_ticks   (r_cfg[g][31:16]),
            .lo_ticks   (r_cfg[g][15:0]),
            .idle_level (r_idle_level[g]),
            .run        (w_run),
            .level      (w_level[g])
        );
    end

endmodule

// File: tb/tb_io_stim_gen.sv
// Self-checking bench for io_stim_gen: register table, directed burst,
// stop/restart/reset sequences and randomized bursts against a phase model.
module tb_io_stim_gen;

    localparam int TD = 4;
    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] io_out;
    logic [NL-1:0] io_oe;

    io_stim_gen_if bus ();

    io_stim_gen #(
        .TICK_DIV (TD),
        .N_LINES  (NL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .io_out (io_out),
        .io_oe  (io_oe)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       mHi [NL];
    int       mLo [NL];
    logic [7:0] mOe;
    logic [7:0] mIdle;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus access, entered and left #1 after a rising edge.
    task automatic applyStimulus(input bit we, input logic [3:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        bus.wb_cyc   = 1'b1;
        bus.wb_we    = we;
        bus.wb_addr  = addr;
        bus.wb_wdata = wdata;
        checkOutput("ackBeforeEdge", {31'b0, bus.wb_ack}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ackAfterOneCycle", {31'b0, bus.wb_ack}, 32'd1);
        rdata = bus.wb_rdata;
        @(posedge clk);
        #1;
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
    endtask

    task automatic writeCfg(input int line, input int hi, input int lo);
        logic [31:0] rd;
        applyStimulus(1'b1, 4'(line), {16'(hi), 16'(lo)}, rd);
        mHi[line] = hi;
        mLo[line] = lo;
    endtask

    task automatic writeCtrl(input logic [7:0] oe, input logic [7:0] idle);
        logic [31:0] rd;
        applyStimulus(1'b1, 4'h8, {16'h0, idle, oe}, rd);
        mOe   = oe;
        mIdle = idle;
    endtask

    task automatic readCheck(input logic [3:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        applyStimulus(1'b0, addr, 32'h0, rd);
        checkOutput(name, rd, exp);
    endtask

    // Output n cycles after the START edge: tick index t=(n-1)/TD selects a
    // position in the hi+lo period; outside the burst the line is idle.
    function automatic logic [7:0] modelOut(input int n, input int len);
        logic [7:0] v;
        int period;
        for (int i = 0; i < NL; i++) begin
            period = mHi[i] + mLo[i];
            if ((n - 1) >= len * TD || period == 0)
                v[i] = mIdle[i];
            else
                v[i] = ((((n - 1) / TD) % period) < mHi[i]);
        end
        return v;
    endfunction

    task automatic runAndCheck(input int len, input int cycles, input string tag);
        logic [31:0] rd;
        applyStimulus(1'b1, 4'h9, 32'(len), rd);
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk);
            #1;
            checkOutput(tag, {16'h0, io_oe, io_out}, {16'h0, mOe, modelOut(n, len)});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int len;

        bus.wb_cyc   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_wdata = '0;
        for (int i = 0; i < NL; i++) begin
            mHi[i] = 0;
            mLo[i] = 0;
        end
        mOe   = 8'h00;
        mIdle = 8'h00;

        #1;
        checkOutput("resetIo", {16'h0, io_oe, io_out}, 32'h0);
        checkOutput("resetAck", {31'b0, bus.wb_ack}, 32'd0);
        checkOutput("resetRdata", bus.wb_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Register table: reset reads, read-back, masking and ignored addresses.
        for (int a = 0; a <= 10; a++) vecs.push_back('{1'b0, 4'(a), 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'h3, 32'h1234_5678, 32'h0});
        vecs.push_back('{1'b0, 4'h3, 32'h0,         32'h1234_5678});
        vecs.push_back('{1'b1, 4'h8, 32'hFFFF_ABCD, 32'h0});
        vecs.push_back('{1'b0, 4'h8, 32'h0,         32'h0000_ABCD});
        vecs.push_back('{1'b1, 4'hB, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 4'hB, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 4'hA, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 4'hA, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'h9, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 4'h3, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 4'h8, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'h3, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 4'h8, 32'h0,         32'h0});
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].we, vecs[k].addr, vecs[k].wdata, rd);
            if (!vecs[k].we) checkOutput($sformatf("regVec%0d", k), rd, vecs[k].expRdata);
        end
        checkOutput("rdataWhenIdle", bus.wb_rdata, 32'h0);
        checkOutput("ioAfterTable", {16'h0, io_oe, io_out}, 32'h0);

        // Line0 3 ticks high / 2 low, 10-tick burst.
        writeCfg(0, 3, 2);
        writeCtrl(8'h01, 8'h00);
        runAndCheck(10, 44, "burst10");
        readCheck(4'h9, 32'h0, "burst10Done");

        // Skipped HI phase and all-zero line holding idle.
        writeCfg(1, 0, 5);
        writeCfg(2, 0, 0);
        writeCtrl(8'h07, 8'h04);
        runAndCheck(6, 27, "skipPhase");
        checkOutput("line2Idle", {31'b0, io_out[2]}, 32'd1);
        checkOutput("line1Low", {31'b0, io_out[1]}, 32'd0);

        // STOP mid-run.
        applyStimulus(1'b1, 4'h9, 32'd100, rd);
        readCheck(4'h9, 32'h8000_0064, "startRead");
        repeat (13) @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'hA, 32'h0, rd);
        @(posedge clk);
        #1;
        checkOutput("stopIdle", {16'h0, io_oe, io_out}, {16'h0, mOe, mIdle});
        applyStimulus(1'b0, 4'h9, 32'h0, rd);
        checkOutput("stopBusy", {31'b0, rd[31]}, 32'd0);

        // Zero-length START.
        runAndCheck(0, 8, "lenZero");
        readCheck(4'h9, 32'h0, "lenZeroBusy");

        // Restart while running.
        applyStimulus(1'b1, 4'h9, 32'd100, rd);
        repeat (6) @(posedge clk);
        #1;
        runAndCheck(3, 15, "restart");
        readCheck(4'h9, 32'h0, "restartDone");

        // Randomized bursts.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NL; i++) writeCfg(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            writeCtrl(8'($urandom), 8'($urandom));
            len = int'($urandom_range(1, 6));
            runAndCheck(len, len * TD + 3, "randRun");
            readCheck(4'h9, 32'h0, "randDone");
        end

        // Asynchronous reset mid-run.
        writeCtrl(8'hFF, 8'hF0);
        applyStimulus(1'b1, 4'h9, 32'd50, rd);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetIo", {16'h0, io_oe, io_out}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) begin
            mHi[i] = 0;
            mLo[i] = 0;
        end
        mOe   = 8'h00;
        mIdle = 8'h00;
        @(posedge clk);
        #1;
        readCheck(4'h9, 32'h0, "postResetBusy");
        readCheck(4'h0, 32'h0, "postResetCfg0");
        readCheck(4'h8, 32'h0, "postResetCtrl");
        checkOutput("postResetIo", {16'h0, io_oe, io_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
